// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the DataMemory round-robin arbiter.
// Provides the arbiter FSM state type, the default bus widths and the
// requester-index width helper used by dmem_arbiter and rr_picker.

`ifndef DATAMEM_ADDR_WIDTH
`define DATAMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WORD_LENGTH
`define DATA_WORD_LENGTH 32
`endif

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int DEF_ADDR_W = `DATAMEM_ADDR_WIDTH;
    localparam int DEF_DATA_W = `DATA_WORD_LENGTH;

    // A single requester still needs a 1-bit index so every vector stays legal.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority select over an N_CORES request vector.
// Ports: req_i (request vector), ptr_i (last winner), any_o (some request set),
//        winner_o (first set bit searching ptr_i+1, ptr_i+2, ... modulo N_CORES).

module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int IDX_W   = idx_w(N_CORES)
) (
    input  logic [N_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   winner_o
);

    // Offset 1 is checked first, so the last winner only wins again when
    // it is the sole requester (offset N_CORES wraps back onto ptr_i).
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N_CORES]) begin
                any_o    = 1'b1;
                winner_o = IDX_W'((int'(ptr_i) + k) % N_CORES);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port DataMemory among N_CORES requesters.
// Ports: clk_i/reset_i; per-lane req_i/wr_en_i/addr_i/wdata_i in, one-hot gnt_o/done_o
//        and broadcast rdata_o out; mem_addr_o/mem_wdata_o/mem_wr_en_o/mem_rdata_i to memory.

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [N_CORES-1:0]        req_i,
    input  logic [N_CORES-1:0]        wr_en_i,
    input  logic [N_CORES*ADDR_W-1:0] addr_i,
    input  logic [N_CORES*DATA_W-1:0] wdata_i,
    output logic [N_CORES-1:0]        gnt_o,
    output logic [N_CORES-1:0]        done_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    output logic                      mem_wr_en_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
);

    localparam int               IDX_W   = idx_w(N_CORES);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_CORES - 1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              any_req;
    logic [IDX_W-1:0]  win;

    rr_picker #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .any_o    (any_req),
        .winner_o (win)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        gnt_o       = '0;
        done_o      = '0;
        mem_wr_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = win;
                    wr_d    = wr_en_i[win];
                    addr_d  = addr_i[win*ADDR_W +: ADDR_W];
                    wdata_d = wdata_i[win*DATA_W +: DATA_W];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                gnt_o[idx_q] = 1'b1;
                mem_wr_en_o  = wr_q;
                // Memory runs on the falling edge, so its read word is
                // already settled when this cycle ends.
                rdata_d      = mem_rdata_i;
                state_d      = RESP;
            end
            RESP: begin
                done_o[idx_q] = 1'b1;
                ptr_d         = idx_q;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The latches only change when a winner is taken, so the memory bus
    // holds its last access outside ACCESS.
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign rdata_o     = rdata_q;

endmodule
